stepper_seq: RTL and testbench

Parametrised stepper-motor phase sequencer for the board's 4-pin motor headers (MA–MD). It replaces free-running full-step phase generation with a start/done handshake that runs a programmed number of steps. Step rate, direction and full/half-step mode are set per move, and coil outputs are PWM-gated for current limiting and hold-energised when idle. One instance drives one motor header.

---
 rtl/stepper_pkg.sv | 40 ++++
 rtl/step_timer.sv | 48 ++++
 rtl/stepper_seq.sv | 164 ++++++++++++++++
 tb/tb_stepper_seq.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/stepper_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stepper_pkg
// Description : Shared definitions for the stepper phase sequencer:
//               coil bit positions, the 8-entry phase table and the FSM
//               state type.
// Revision    : 1.0 - initial release
// ============================================================================
package stepper_pkg;

    // Coil drive bit order on the header: {B-, A-, B+, A+}
    localparam int COIL_AP = 0;
    localparam int COIL_BP = 1;
    localparam int COIL_AN = 2;
    localparam int COIL_BN = 3;

    localparam logic [3:0] C_AP = 4'(1 << COIL_AP);
    localparam logic [3:0] C_BP = 4'(1 << COIL_BP);
    localparam logic [3:0] C_AN = 4'(1 << COIL_AN);
    localparam logic [3:0] C_BN = 4'(1 << COIL_BN);

    // Even entries energise one coil, odd entries two (full-step positions).
    localparam logic [3:0] PHASE_TABLE [8] = '{
        C_AP,           // 0: 0001
        C_AP | C_BP,    // 1: 0011
        C_BP,           // 2: 0010
        C_BP | C_AN,    // 3: 0110
        C_AN,           // 4: 0100
        C_AN | C_BN,    // 5: 1100
        C_BN,           // 6: 1000
        C_BN | C_AP     // 7: 1001
    };

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/step_timer.sv
`default_nettype none
// ============================================================================
// Module      : step_timer
// Description : Step-period divider. Counts 0..div_i while enabled and
//               raises tick_o for the single cycle in which the count equals
//               div_i; the count then wraps to 0. clr_i holds it at 0.
// Ports       : clk_i, rst_i (async, active high)
//               clr_i   - synchronous clear (dominates en_i)
//               en_i    - count enable
//               div_i   - terminal count (period minus one)
//               tick_o  - one-cycle step strobe
// Revision    : 1.0 - initial release
// ============================================================================
module step_timer #(
    parameter int DIV_W = 20
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    assign tick_o = en_i && !clr_i && (cnt_q == div_i);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tick_o ? '0 : cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/stepper_seq.sv
`default_nettype none
// ============================================================================
// Module      : stepper_seq
// Description : Stepper-motor phase sequencer for one 4-pin motor header.
//               A start/done handshake runs a programmed number of steps at
//               a programmed rate, direction and full/half-step mode. Coil
//               drive is PWM-gated and optionally held energised when idle.
// Ports       : clk_i, rst_i     - clock, async active-high reset
//               start_i, stop_i  - begin move (IDLE) / abort move (RUN)
//               steps_i, div_i,
//               dir_i, half_i    - move parameters, latched on start
//               hold_i, duty_i   - idle hold and PWM on-level (live)
//               coil_o           - registered coil drive {B-,A-,B+,A+}
//               busy_o, done_o   - running flag, completion pulse
//               pos_o            - signed step position (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module stepper_seq
    import stepper_pkg::*;
#(
    parameter int DIV_W = 20,
    parameter int CNT_W = 16,
    parameter int PWM_W = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic [CNT_W-1:0] steps_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic             dir_i,
    input  logic             half_i,
    input  logic             hold_i,
    input  logic [PWM_W-1:0] duty_i,
    output logic [3:0]       coil_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] pos_o
);

    state_t           state_q, state_d;
    logic [2:0]       ph_q,    ph_d;
    logic [CNT_W-1:0] pos_q,   pos_d;
    logic [CNT_W-1:0] rem_q,   rem_d;
    logic [DIV_W-1:0] div_q,   div_d;
    logic             dir_q,   dir_d;
    logic             half_q,  half_d;
    logic             done_q,  done_d;
    logic [3:0]       coil_q,  coil_d;
    logic [PWM_W-1:0] pc_q;

    logic             tick_w;
    logic             gate_w;
    logic [2:0]       ph_inc_w;
    logic [CNT_W-1:0] pos_inc_w;

    // Divider runs only in RUN and is held clear in IDLE, so every move
    // starts counting from 0 on the cycle after start is accepted.
    step_timer #(
        .DIV_W (DIV_W)
    ) u_step_timer (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (state_q == ST_IDLE),
        .en_i   (state_q == ST_RUN),
        .div_i  (div_q),
        .tick_o (tick_w)
    );

    assign gate_w = (pc_q <= duty_i);

    // Phase moves by one table entry per half step, two per full step;
    // mod-8 wrap falls out of the 3-bit add.
    assign ph_inc_w  = half_q ? (dir_q ? 3'd1 : 3'd7)
                              : (dir_q ? 3'd2 : 3'd6);
    assign pos_inc_w = dir_q ? CNT_W'(1) : {CNT_W{1'b1}};

    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        pos_d   = pos_q;
        rem_d   = rem_q;
        div_d   = div_q;
        dir_d   = dir_q;
        half_d  = half_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (steps_i != '0) begin
                        state_d = ST_RUN;
                        rem_d   = steps_i;
                        div_d   = div_i;
                        dir_d   = dir_i;
                        half_d  = half_i;
                        // Full steps must sit on two-coil (odd) entries.
                        if (!half_i) begin
                            ph_d[0] = 1'b1;
                        end
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                // stop takes priority over a step due in the same cycle.
                if (stop_i) begin
                    state_d = ST_IDLE;
                end else if (tick_w) begin
                    ph_d  = ph_q + ph_inc_w;
                    pos_d = pos_q + pos_inc_w;
                    rem_d = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if ((state_q == ST_RUN) || hold_i) begin
            coil_d = PHASE_TABLE[ph_q] & {4{gate_w}};
        end else begin
            coil_d = 4'b0000;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            ph_q    <= 3'd0;
            pos_q   <= '0;
            rem_q   <= '0;
            div_q   <= '0;
            dir_q   <= 1'b0;
            half_q  <= 1'b0;
            done_q  <= 1'b0;
            coil_q  <= 4'b0000;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            pos_q   <= pos_d;
            rem_q   <= rem_d;
            div_q   <= div_d;
            dir_q   <= dir_d;
            half_q  <= half_d;
            done_q  <= done_d;
            coil_q  <= coil_d;
            pc_q    <= pc_q + PWM_W'(1);
        end
    end

    assign coil_o = coil_q;
    assign busy_o = (state_q == ST_RUN);
    assign done_o = done_q;
    assign pos_o  = pos_q;

endmodule
`default_nettype wire

// File: tb/tb_stepper_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_stepper_seq
// Description : Directed self-checking bench for stepper_seq.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stepper_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic        stop;
    logic [15:0] steps;
    logic [19:0] div;
    logic        dir;
    logic        half;
    logic        hold;
    logic [1:0]  duty;
    logic [3:0]  coil;
    logic        busy;
    logic        done;
    logic [15:0] pos;

    int n_vec = 0;
    int n_err = 0;

    // Expected phase table, {B-,A-,B+,A+}
    logic [3:0] tbl [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                            4'b0100, 4'b1100, 4'b1000, 4'b1001};

    stepper_seq #(
        .DIV_W (20),
        .CNT_W (16),
        .PWM_W (2)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start),
        .stop_i  (stop),
        .steps_i (steps),
        .div_i   (div),
        .dir_i   (dir),
        .half_i  (half),
        .hold_i  (hold),
        .duty_i  (duty),
        .coil_o  (coil),
        .busy_o  (busy),
        .done_o  (done),
        .pos_o   (pos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds start for one edge; returns one cycle after that edge (t+1).
    task automatic pulse_start(input logic [15:0] s, input logic [19:0] d,
                               input logic dr, input logic h);
        steps = s; div = d; dir = dr; half = h; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        start = 0; stop = 0; steps = 0; div = 0; dir = 0; half = 0;
        hold = 0; duty = 2'd3;
        rst = 1'b1;
        tick();
        n_vec++; if (coil !== 4'b0000) begin n_err++; $display("FAIL reset_coil got=%b exp=0000", coil); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", done); end
        n_vec++; if (pos !== 16'd0) begin n_err++; $display("FAIL reset_pos got=%0d exp=0", pos); end
        rst = 1'b0;
        tick();
        hold = 1'b1;
        tick();
    endtask

    // Half step forward, div=3, steps=5, starting from ph=0, pos=0.
    task automatic test_half_step();
        hold = 1'b1; duty = 2'd3;
        pulse_start(16'd5, 20'd3, 1'b1, 1'b1);                       // t+1
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL half_busy_rise got=%b exp=1", busy); end
        for (int k = 1; k <= 5; k++) begin
            repeat (3) tick();                                        // t+4k
            n_vec++; if (pos !== 16'(k - 1)) begin n_err++; $display("FAIL half_pos_pre k=%0d got=%0d exp=%0d", k, pos, k - 1); end
            n_vec++; if (coil !== tbl[k - 1]) begin n_err++; $display("FAIL half_coil k=%0d got=%b exp=%b", k, coil, tbl[k - 1]); end
            n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL half_done_early k=%0d got=%b exp=0", k, done); end
            tick();                                                   // t+4k+1
            n_vec++; if (pos !== 16'(k)) begin n_err++; $display("FAIL half_pos_step k=%0d got=%0d exp=%0d", k, pos, k); end
        end
        n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL half_done got=%b exp=1", done); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL half_busy_fall got=%b exp=0", busy); end
        tick();                                                       // t+22
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL half_done_width got=%b exp=0", done); end
        n_vec++; if (coil !== tbl[5]) begin n_err++; $display("FAIL half_coil_end got=%b exp=%b", coil, tbl[5]); end
    endtask

    // Full step reverse, div=0, steps=4 from ph=0.
    task automatic test_full_reverse();
        logic [3:0] exp_coil [5] = '{4'b0011, 4'b1001, 4'b1100, 4'b0110, 4'b0011};
        apply_reset();
        hold = 1'b1; duty = 2'd3;
        pulse_start(16'd4, 20'd0, 1'b0, 1'b0);                       // t+1
        for (int i = 0; i < 5; i++) begin
            tick();                                                   // t+2+i
            n_vec++; if (coil !== exp_coil[i]) begin n_err++; $display("FAIL full_coil i=%0d got=%b exp=%b", i, coil, exp_coil[i]); end
            n_vec++; if (pos !== 16'(-((i < 4) ? i + 1 : 4))) begin n_err++; $display("FAIL full_pos i=%0d got=%0d exp=%0d", i, $signed(pos), -((i < 4) ? i + 1 : 4)); end
            n_vec++; if (done !== (i == 3)) begin n_err++; $display("FAIL full_done i=%0d got=%b exp=%b", i, done, (i == 3)); end
        end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL full_busy_end got=%b exp=0", busy); end
    endtask

    // steps=0 start: immediate done, no motion (ph=1, pos=-4 from before).
    task automatic test_zero_steps();
        pulse_start(16'd0, 20'd2, 1'b1, 1'b1);                       // t+1
        n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL zero_done got=%b exp=1", done); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL zero_busy got=%b exp=0", busy); end
        tick();
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL zero_done_width got=%b exp=0", done); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL zero_busy2 got=%b exp=0", busy); end
        n_vec++; if (pos !== 16'hFFFC) begin n_err++; $display("FAIL zero_pos got=%0d exp=-4", $signed(pos)); end
        n_vec++; if (coil !== 4'b0011) begin n_err++; $display("FAIL zero_coil got=%b exp=0011", coil); end
    endtask

    // div=9, steps=10; start during RUN ignored; stop on the third tick.
    task automatic test_stop_abort();
        pulse_start(16'd10, 20'd9, 1'b1, 1'b1);                      // t+1
        repeat (10) tick();                                           // t+11
        n_vec++; if (pos !== 16'hFFFD) begin n_err++; $display("FAIL stop_pos1 got=%0d exp=-3", $signed(pos)); end
        repeat (4) tick();                                            // t+15
        steps = 16'd0; start = 1'b1;
        tick();                                                       // t+16
        start = 1'b0;
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL stop_start_ignored_done got=%b exp=0", done); end
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL stop_start_ignored_busy got=%b exp=1", busy); end
        repeat (5) tick();                                            // t+21
        n_vec++; if (pos !== 16'hFFFE) begin n_err++; $display("FAIL stop_pos2 got=%0d exp=-2", $signed(pos)); end
        repeat (9) tick();                                            // t+30, tick cycle
        stop = 1'b1;
        tick();                                                       // t+31
        stop = 1'b0;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL stop_busy got=%b exp=0", busy); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL stop_done got=%b exp=0", done); end
        n_vec++; if (pos !== 16'hFFFE) begin n_err++; $display("FAIL stop_pos_suppressed got=%0d exp=-2", $signed(pos)); end
        tick();
        tick();
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL stop_done_late got=%b exp=0", done); end
        n_vec++; if (coil !== tbl[3]) begin n_err++; $display("FAIL stop_coil got=%b exp=%b", coil, tbl[3]); end
    endtask

    // Idle hold PWM at ph=3: duty=1 -> 4 of 8 cycles on; duty=0 -> 2 of 8.
    task automatic test_pwm();
        int n_on;
        int n_off;
        hold = 1'b1; duty = 2'd1;
        tick(); tick();
        n_on = 0; n_off = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (coil === tbl[3]) n_on++;
            else if (coil === 4'b0000) n_off++;
        end
        n_vec++; if (n_on !== 4 || n_off !== 4) begin n_err++; $display("FAIL pwm_duty1 got on=%0d off=%0d exp on=4 off=4", n_on, n_off); end
        duty = 2'd0;
        tick(); tick();
        n_on = 0; n_off = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (coil === tbl[3]) n_on++;
            else if (coil === 4'b0000) n_off++;
        end
        n_vec++; if (n_on !== 2 || n_off !== 6) begin n_err++; $display("FAIL pwm_duty0 got on=%0d off=%0d exp on=2 off=6", n_on, n_off); end
        hold = 1'b0; duty = 2'd3;
        tick(); tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            n_vec++; if (coil !== 4'b0000) begin n_err++; $display("FAIL pwm_nohold i=%0d got=%b exp=0000", i, coil); end
        end
    endtask

    // Async reset between edges mid-move, then a fresh move as in the first test.
    task automatic test_async_reset();
        hold = 1'b1; duty = 2'd3;
        pulse_start(16'd5, 20'd3, 1'b1, 1'b1);                       // t+1
        repeat (6) tick();                                            // t+7
        n_vec++; if (pos !== 16'hFFFF) begin n_err++; $display("FAIL areset_pre_pos got=%0d exp=-1", $signed(pos)); end
        #3;
        rst = 1'b1;
        #1;
        n_vec++; if (coil !== 4'b0000) begin n_err++; $display("FAIL areset_coil got=%b exp=0000", coil); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL areset_busy got=%b exp=0", busy); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL areset_done got=%b exp=0", done); end
        n_vec++; if (pos !== 16'd0) begin n_err++; $display("FAIL areset_pos got=%0d exp=0", pos); end
        tick();
        rst = 1'b0;
        tick();
        test_half_step();
    endtask

    initial begin
        test_reset();
        test_half_step();
        test_full_reverse();
        test_zero_steps();
        test_stop_abort();
        test_pwm();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
